// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, burst length and round-robin pick for the memory bus arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam int BEATS = 8;
  function automatic logic rr_pick(input logic [1:0] reqs, input logic last_grant);
    return (reqs == 2'b11) ? ~last_grant : reqs[1];
  endfunction
endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one Sysbus memory port between icache (0) and dcache (1)
module mem_bus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH = 13,
  parameter int BEATS = mem_arb_pkg::BEATS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  c_reqcyc,
  output logic [1:0]                  c_reqack,
  input  logic [2*BUS_DATA_WIDTH-1:0] c_req,
  input  logic [2*BUS_TAG_WIDTH-1:0]  c_reqtag,
  output logic [1:0]                  c_respcyc,
  input  logic [1:0]                  c_respack,
  output logic [BUS_DATA_WIDTH-1:0]   c_resp,
  output logic [BUS_TAG_WIDTH-1:0]    c_resptag,
  output logic                        m_bus_reqcyc,
  input  logic                        m_bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0]   m_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]    m_bus_reqtag,
  input  logic                        m_bus_respcyc,
  output logic                        m_bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0]   m_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]    m_bus_resptag
);
  import mem_arb_pkg::*;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  state_t state;
  logic grant, last_grant, pick;
  logic [CNT_W-1:0] beat_cnt;
  logic [BUS_DATA_WIDTH-1:0] addr;
  logic [BUS_TAG_WIDTH-1:0] tag;
  logic in_req, in_resp;
  assign pick = rr_pick(c_reqcyc, last_grant);
  assign in_req = state == REQ;
  assign in_resp = state == RESP;
  always_comb begin
    m_bus_reqcyc = in_req;
    m_bus_req = addr;
    m_bus_reqtag = tag;
    c_reqack = (in_req && m_bus_reqack) ? 2'b01 << grant : 2'b00;
    c_respcyc = (in_resp && m_bus_respcyc) ? 2'b01 << grant : 2'b00;
    m_bus_respack = in_resp && m_bus_respcyc && c_respack[grant];
    c_resp = m_bus_resp;
    c_resptag = m_bus_resptag;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt <= '0;
      addr <= '0;
      tag <= '0;
    end else begin
      case (state)
        IDLE: if (|c_reqcyc) begin
          grant <= pick;
          addr <= pick ? c_req[2*BUS_DATA_WIDTH-1:BUS_DATA_WIDTH] : c_req[BUS_DATA_WIDTH-1:0];
          tag <= pick ? c_reqtag[2*BUS_TAG_WIDTH-1:BUS_TAG_WIDTH] : c_reqtag[BUS_TAG_WIDTH-1:0];
          state <= REQ;
        end
        REQ: if (m_bus_reqack) state <= RESP;
        RESP: if (m_bus_respack) begin
          if (beat_cnt == CNT_W'(BEATS - 1)) begin
            beat_cnt <= '0;
            last_grant <= grant;
            state <= IDLE;
          end else beat_cnt <= beat_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single DRAM-side Sysbus port between two cache clients: client 0 is the instruction cache and client 1 is the data cache.
- Grants one client at a time, round-robin.
- Forwards that client's read request to memory and steers the multi-beat response back to it.
- Holds the grant until the last beat is acknowledged.
- Sits between the cache controllers and the top-level memory bus.

Parameters:
BUS_DATA_WIDTH, 64, address/data width of each bus
BUS_TAG_WIDTH, 13, request/response tag width
BEATS, 8, response beats per transaction (64-byte line / 8 bytes)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
c_reqcyc  in  2  per-client request valid (bit i = client i)
c_reqack  out  2  per-client request accepted
c_req  in  2*BUS_DATA_WIDTH  per-client request address, client i at slice [i*W +: W]
c_reqtag  in  2*BUS_TAG_WIDTH  per-client request tag
c_respcyc  out  2  per-client response beat valid
c_respack  in  2  per-client response beat accepted
c_resp  out  BUS_DATA_WIDTH  response data, shared by both clients
c_resptag  out  BUS_TAG_WIDTH  response tag, shared by both clients
m_bus_reqcyc  out  1  memory request valid
m_bus_reqack  in  1  memory request accepted
m_bus_req  out  BUS_DATA_WIDTH  memory request address
m_bus_reqtag  out  BUS_TAG_WIDTH  memory request tag
m_bus_respcyc  in  1  memory response beat valid
m_bus_respack  out  1  memory response beat accepted
m_bus_resp  in  BUS_DATA_WIDTH  memory response data
m_bus_resptag  in  BUS_TAG_WIDTH  memory response tag

Behaviour:
- Reset (synchronous): state=IDLE, last_grant=1 (client 0 wins the first tie), beat_cnt=0, latched addr/tag=0. All cyc/ack outputs are 0 in the cycle after reset is sampled.
- States: IDLE, REQ, RESP.
- IDLE, no request: no outputs asserted.
- IDLE, any c_reqcyc high:
  - Only one high: that client wins.
  - Both high: client !last_grant wins.
  - Latch grant, c_req[grant] and c_reqtag[grant]; go to REQ.
- REQ:
  - m_bus_reqcyc=1; m_bus_req and m_bus_reqtag driven from the latched values.
  - c_reqack[grant]=m_bus_reqack, combinational pass-through.
  - On m_bus_reqack=1, go to RESP.
- RESP:
  - c_respcyc[grant]=m_bus_respcyc; c_respcyc of the other client is 0.
  - c_resp=m_bus_resp and c_resptag=m_bus_resptag, always passed through.
  - m_bus_respack=m_bus_respcyc & c_respack[grant].
  - A beat completes when m_bus_respcyc & m_bus_respack; beat_cnt increments on each completed beat.
  - On the completing beat with beat_cnt==BEATS-1: beat_cnt<=0, last_grant<=grant, go to IDLE.
- Latency: request seen at cycle N → m_bus_reqcyc at N+1. There is at least one IDLE cycle between transactions.
- No preemption. A request raised by the non-granted client waits; it is served next even if the previous owner re-requests immediately.
- Once latched, the arbiter ignores c_reqcyc and c_req changes from the granted client. Clients hold reqcyc until reqack regardless.
- The non-granted client never sees reqack or respcyc.
- c_respack from the non-granted client, and c_respack while m_bus_respcyc=0, are ignored.
- Response tags are passed through unchecked.
- Reset mid-REQ or mid-RESP aborts the transaction: IDLE, beat_cnt=0, last_grant=1. No further acks or cycs are issued for the aborted transaction.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE/REQ/RESP), BEATS constant, rr_pick(reqs, last_grant) function.
- No sub-module; single module.

Test Plan:
- Client 0 only requests 0x1000, tag 0x05 → m_bus_reqcyc the next cycle with req=0x1000, tag=0x05. Eight beats 0xA0..0xA7 arrive only on c_respcyc[0]. m_bus_respack is asserted on each beat. The arbiter returns to IDLE after beat 7.
- Both clients request in the same cycle out of reset → client 0 is served first, then client 1 with its own address 0x2000. The next simultaneous request goes to client 0 (strict alternation).
- Client 0 holds c_respack=0 for 3 cycles mid-burst → m_bus_respack stays 0 and beat_cnt is unchanged. Data is not lost; exactly 8 beats complete.
- m_bus_reqack is delayed 5 cycles → c_reqack[grant] pulses exactly in the ack cycle; the other client's reqack stays 0 throughout.
- Reset asserted after beat 3 → the next cycle is IDLE with all outputs 0. A new client 1 request then completes a full 8-beat burst.
- Client 1 pulses respack with m_bus_respcyc=0, and client 0 (non-granted) asserts respack → no beat is counted and m_bus_respack=0.
